// File: rtl/tff_bank_sequencer.sv
// Up/down step sequencer for a bank of negedge-triggered T flip-flops; T vectors issued on posedge.
// Optional readback checking of the bank against the shadow count: define TFF_READBACK_CHECK_EN.
module tff_bank_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        SYNC0 = 3'd0,
        SYNC1 = 3'd1,
        IDLE  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] t_nxt, count_nxt, step_val;
    logic             busy_nxt, done_nxt, dir_q, dir_nxt, step_dir;

    // The first step of a run uses the dir input directly, since dir_q is latched on that same edge.
    assign step_dir = (state == IDLE) ? dir : dir_q;
    assign step_val = step_dir ? (count + WIDTH'(1)) : (count - WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SYNC0;
            t_vec <= '0;
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            dir_q <= 1'b1;
        end else begin
            state <= state_nxt;
            t_vec <= t_nxt;
            count <= count_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            dir_q <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        t_nxt     = '0;
        count_nxt = count;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        dir_nxt   = dir_q;
        case (state)
            SYNC0: begin
                // Toggling exactly the bits that read 1 drives the whole bank to 0.
                t_nxt     = q_fb;
                busy_nxt  = 1'b1;
                state_nxt = SYNC1;
            end
            SYNC1: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            IDLE: begin
                busy_nxt = 1'b0;
                if (stop) begin
                    state_nxt = IDLE;
                end else if (clr) begin
                    t_nxt     = count;
                    count_nxt = '0;
                end else if (start) begin
                    if (count == limit) begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        dir_nxt   = dir;
                        busy_nxt  = 1'b1;
                        t_nxt     = count ^ step_val;
                        count_nxt = step_val;
                        state_nxt = RUN;
                        if (step_val == limit) begin
                            done_nxt  = 1'b1;
                            busy_nxt  = 1'b0;
                            state_nxt = DONE;
                        end
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    t_nxt     = count ^ step_val;
                    count_nxt = step_val;
                    if (step_val == limit) begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b1;
                state_nxt = SYNC0;
            end
        endcase
    end

`ifdef TFF_READBACK_CHECK_EN
    // Bank and shadow count agree at every posedge once the SYNC0 clearing toggle has landed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == IDLE && !stop && clr) begin
            err <= 1'b0;
        end else if (state != SYNC0 && q_fb != count) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Directed bench for tff_bank_sequencer: behavioural negedge T-flop bank, vector table and a stuck-bit sequence.
module tb_tff_bank_sequencer;

    localparam int WIDTH = 4;
`ifdef TFF_READBACK_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0, stop = 1'b0, clr = 1'b0, dir = 1'b1;
    logic [WIDTH-1:0] limit = '0;
    logic [WIDTH-1:0] q_fb, t_vec, count;
    logic             busy, done, err;
    logic [WIDTH-1:0] q_bank = 4'b1010;
    logic             stuck0 = 1'b0;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Bank model: one T flip-flop per bit, toggling on the falling edge.
    always @(negedge clk) q_bank <= q_bank ^ t_vec;
    assign q_fb = q_bank & ~{{(WIDTH-1){1'b0}}, stuck0};

    tff_bank_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr), .dir(dir),
        .limit(limit), .q_fb(q_fb), .t_vec(t_vec), .count(count), .busy(busy),
        .done(done), .err(err)
    );

    typedef struct {
        logic             start, stop, clr, dir;
        logic [WIDTH-1:0] limit;
        logic [WIDTH-1:0] t, c, q;
        logic             busy, done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic p, input logic k, input logic d,
                                input logic [3:0] l, input logic [3:0] t, input logic [3:0] c,
                                input logic [3:0] q, input logic b, input logic dn);
        vec_t v;
        v.start = s; v.stop = p; v.clr = k; v.dir = d; v.limit = l;
        v.t = t; v.c = c; v.q = q; v.busy = b; v.done = dn;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Columns: start stop clr dir limit | t_vec count q_fb busy done (sampled 1ns after posedge)
        vecs.push_back(mk(1,0,1,0, 7, 4'b1010, 0, 4'b1010, 1, 0)); // SYNC0 flush, inputs ignored
        vecs.push_back(mk(1,0,1,0, 7, 4'b0000, 0, 4'b0000, 0, 0)); // SYNC1
        vecs.push_back(mk(0,0,0,0, 7, 4'b0000, 0, 4'b0000, 0, 0));
        vecs.push_back(mk(1,0,0,1, 5, 4'b0001, 1, 4'd0, 1, 0));    // up 0 -> 5
        vecs.push_back(mk(0,0,0,0, 5, 4'b0011, 2, 4'd1, 1, 0));
        vecs.push_back(mk(0,0,0,1, 5, 4'b0001, 3, 4'd2, 1, 0));
        vecs.push_back(mk(0,0,0,1, 5, 4'b0111, 4, 4'd3, 1, 0));
        vecs.push_back(mk(0,0,0,1, 5, 4'b0001, 5, 4'd4, 0, 1));
        vecs.push_back(mk(1,0,1,0, 5, 4'b0000, 5, 4'd5, 0, 0));    // DONE ignores inputs
        vecs.push_back(mk(0,0,0,1, 5, 4'b0000, 5, 4'd5, 0, 0));
        vecs.push_back(mk(0,0,1,1, 5, 4'b0101, 0, 4'd5, 0, 0));    // clr from 5
        vecs.push_back(mk(0,0,0,1, 5, 4'b0000, 0, 4'd0, 0, 0));
        vecs.push_back(mk(1,0,0,1, 2, 4'b0001, 1, 4'd0, 1, 0));    // reach 2
        vecs.push_back(mk(0,0,0,1, 2, 4'b0011, 2, 4'd1, 0, 1));
        vecs.push_back(mk(0,0,0,1, 2, 4'b0000, 2, 4'd2, 0, 0));
        vecs.push_back(mk(1,0,0,0,14, 4'b0011, 1, 4'd2, 1, 0));    // down 2 -> 14 with wrap
        vecs.push_back(mk(0,0,1,0,14, 4'b0001, 0, 4'd1, 1, 0));    // clr ignored in RUN
        vecs.push_back(mk(1,0,0,0,14, 4'b1111,15, 4'd0, 1, 0));    // start ignored in RUN
        vecs.push_back(mk(0,0,0,0,14, 4'b0001,14, 4'd15,0, 1));
        vecs.push_back(mk(0,0,0,0,14, 4'b0000,14, 4'd14,0, 0));
        vecs.push_back(mk(0,0,1,0,14, 4'b1110, 0, 4'd14,0, 0));
        vecs.push_back(mk(1,0,0,1, 9, 4'b0001, 1, 4'd0, 1, 0));    // up toward 9, stopped at 3
        vecs.push_back(mk(0,0,0,1, 9, 4'b0011, 2, 4'd1, 1, 0));
        vecs.push_back(mk(0,0,0,1, 9, 4'b0001, 3, 4'd2, 1, 0));
        vecs.push_back(mk(0,1,0,1, 9, 4'b0000, 3, 4'd3, 0, 0));
        vecs.push_back(mk(0,0,0,1, 9, 4'b0000, 3, 4'd3, 0, 0));
        vecs.push_back(mk(1,0,0,1, 9, 4'b0111, 4, 4'd3, 1, 0));    // resume from 3
        vecs.push_back(mk(0,1,0,1, 9, 4'b0000, 4, 4'd4, 0, 0));
        vecs.push_back(mk(1,0,0,1, 6, 4'b0001, 5, 4'd4, 1, 0));
        vecs.push_back(mk(0,0,0,1, 6, 4'b0011, 6, 4'd5, 0, 1));
        vecs.push_back(mk(0,0,0,1, 6, 4'b0000, 6, 4'd6, 0, 0));
        vecs.push_back(mk(1,0,1,1, 9, 4'b0110, 0, 4'd6, 0, 0));    // clr beats start
        vecs.push_back(mk(0,0,0,1, 9, 4'b0000, 0, 4'd0, 0, 0));
        vecs.push_back(mk(1,0,0,1, 0, 4'b0000, 0, 4'd0, 0, 1));    // start at limit: done, no toggle
        vecs.push_back(mk(0,0,0,1, 0, 4'b0000, 0, 4'd0, 0, 0));
        vecs.push_back(mk(1,0,0,1, 3, 4'b0001, 1, 4'd0, 1, 0));    // limit lowered mid-run
        vecs.push_back(mk(0,0,0,1, 2, 4'b0011, 2, 4'd1, 0, 1));
        vecs.push_back(mk(0,0,0,1, 2, 4'b0000, 2, 4'd2, 0, 0));
        vecs.push_back(mk(0,0,1,1, 2, 4'b0010, 0, 4'd2, 0, 0));
        vecs.push_back(mk(1,1,1,1, 5, 4'b0000, 0, 4'd0, 0, 0));    // stop beats clr and start

        repeat (2) @(posedge clk);
        #1;
        check("reset_t_vec", 0, t_vec, 0);
        check("reset_count", 0, count, 0);
        check("reset_busy", 0, busy, 1);
        check("reset_done", 0, done, 0);
        check("reset_err", 0, err, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; stop = vecs[i].stop; clr = vecs[i].clr;
            dir = vecs[i].dir; limit = vecs[i].limit;
            tick();
            check("t_vec", i + 1, t_vec, vecs[i].t);
            check("count", i + 1, count, vecs[i].c);
            check("q_fb", i + 1, q_fb, vecs[i].q);
            check("busy", i + 1, busy, vecs[i].busy);
            check("done", i + 1, done, vecs[i].done);
            check("err", i + 1, err, 0);
        end

        // Bit 0 of the readback stuck low during an up count 0 -> 3.
        stuck0 = 1'b1; start = 1'b1; stop = 1'b0; clr = 1'b0; dir = 1'b1; limit = 4'd3;
        tick();
        check("stuck_count1", 1, count, 1);
        check("stuck_err1", 1, err, 0);
        start = 1'b0;
        tick();
        check("stuck_count2", 2, count, 2);
        check("stuck_err2", 2, err, ERR_EN);
        tick();
        check("stuck_done3", 3, done, 1);
        check("stuck_err3", 3, err, ERR_EN);
        tick();
        check("stuck_done4", 4, done, 0);
        check("stuck_err4", 4, err, ERR_EN);
        stuck0 = 1'b0; clr = 1'b1;
        tick();
        check("stuck_clr_t", 5, t_vec, 4'b0011);
        check("stuck_clr_count", 5, count, 0);
        check("stuck_err5", 5, err, 0);
        clr = 1'b0;
        tick();
        check("stuck_q_fb6", 6, q_fb, 0);
        check("stuck_err6", 6, err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
